// File: rtl/dmem_responder_pkg.sv
// Shared widths, reset level and FSM encodings for the data-memory responder.
package dmem_responder_pkg;

  localparam int   DATA_ADDR_BUS_W   = 32;
  localparam int   DATA_BUS_W        = 32;
  localparam int   DATA_MEM_NUM_LOG2 = 10;
  localparam logic RSTN_ENABLE       = 1'b0;

  typedef enum logic [1:0] {
    DM_IDLE = 2'b00,
    DM_WAIT = 2'b01,
    DM_ACK  = 2'b10
  } dm_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with byte-lane write enables and registered read.
module dmem_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int k = 0; k < 4; k++) begin
          if (i_be[k]) r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
        end
      end else begin
        o_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: accepts a request, waits WAIT cycles, commits/reads, pulses ack.
// States: DM_IDLE wait for req | DM_WAIT count down wait states | DM_ACK commit done, ack next cycle
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int AW_WORDS = DATA_MEM_NUM_LOG2,
  parameter int WAIT     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [DATA_ADDR_BUS_W-1:0] addr_i,
  input  logic [3:0]                 sel_i,
  input  logic [DATA_BUS_W-1:0]      wdata_i,
  output logic                       ack_o,
  output logic [DATA_BUS_W-1:0]      rdata_o,
  output logic                       busy_o
);

  dm_state_t               r_state;
  dm_state_t               w_next;
  logic [3:0]              r_cnt;
  logic                    r_we;
  logic [AW_WORDS-1:0]     r_addr;
  logic [3:0]              r_sel;
  logic [DATA_BUS_W-1:0]   r_wdata;

  logic                    w_accept;
  logic                    w_enter_ack;
  logic                    w_use_in;
  logic                    w_mem_we;
  logic [3:0]              w_mem_be;
  logic [AW_WORDS-1:0]     w_mem_addr;
  logic [DATA_BUS_W-1:0]   w_mem_wdata;
  logic [DATA_BUS_W-1:0]   w_mem_q;
  logic                    w_unused_addr;

  assign w_unused_addr = ^{addr_i[DATA_ADDR_BUS_W-1:AW_WORDS+2], addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst == RSTN_ENABLE) begin
      r_state <= DM_IDLE;
      r_cnt   <= 4'd0;
      ack_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      r_state <= w_next;
      ack_o   <= (r_state == DM_ACK);
      if (r_state == DM_ACK && !r_we) rdata_o <= w_mem_q;
      if (w_accept) r_cnt <= 4'(WAIT);
      else if (r_state == DM_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request fields are frozen at accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= we_i;
      r_addr  <= addr_i[AW_WORDS+1:2];
      r_sel   <= sel_i;
      r_wdata <= wdata_i;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DM_IDLE: if (req_i) w_next = (WAIT == 0) ? DM_ACK : DM_WAIT;
      DM_WAIT: begin
        if (!req_i)              w_next = DM_IDLE;
        else if (r_cnt == 4'd1)  w_next = DM_ACK;
      end
      DM_ACK:  w_next = DM_IDLE;
      default: w_next = DM_IDLE;
    endcase
  end

  // With WAIT=0 the RAM access happens on the accept edge, before capture lands.
  always_comb begin
    busy_o      = (r_state != DM_IDLE);
    w_accept    = (r_state == DM_IDLE) && req_i;
    w_enter_ack = (rst != RSTN_ENABLE) && (w_next == DM_ACK);
    w_use_in    = (r_state == DM_IDLE);
    w_mem_we    = w_use_in ? we_i                    : r_we;
    w_mem_be    = w_use_in ? sel_i                   : r_sel;
    w_mem_addr  = w_use_in ? addr_i[AW_WORDS+1:2]    : r_addr;
    w_mem_wdata = w_use_in ? wdata_i                 : r_wdata;
  end

  dmem_array #(.AW(AW_WORDS)) u_array (
    .clk     (clk),
    .i_en    (w_enter_ack),
    .i_we    (w_mem_we),
    .i_be    (w_mem_be),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_q)
  );

endmodule
